// File: rtl/gmrr_pkg.sv
// ============================================================================
// gmrr_pkg : shared types for the axis_reframer framing logic
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package gmrr_pkg;

  // Framing FSM: S_START while the sample counter is zero, S_MID inside a packet
  typedef enum logic [0:0] {
    S_START = 1'b0,
    S_MID   = 1'b1
  } state_t;

  localparam int DEFAULT_SPP = 4;

endpackage

`default_nettype wire

// File: rtl/axis_skid2.sv
// ============================================================================
// axis_skid2 : 2-entry skid buffer, registered output and registered ready
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module axis_skid2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] out_data;
  logic [W-1:0] skid_data;
  logic         out_valid;
  logic         skid_valid;
  logic         in_ready;
  logic         s_accept;
  logic         out_free;

  assign s_accept = s_valid & in_ready;
  assign out_free = ~out_valid | m_ready;

  // The skid entry only fills when the output register is stalled, so ready
  // drops exactly when both entries hold data.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_data   <= '0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (s_accept) begin
        out_data  <= s_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (s_accept) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign s_ready = in_ready;
  assign m_data  = out_data;
  assign m_valid = out_valid;

endmodule

`default_nettype wire

// File: rtl/axis_reframer.sv
// ============================================================================
// axis_reframer : regenerates tlast every spp accepted samples.
//   Optional macro REFRAME_PASS_TLAST_EN also ends packets on input tlast.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module axis_reframer
  import gmrr_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SPP_LOG2 = 10,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [SPP_LOG2-1:0] spp,
  input  logic [WIDTH-1:0]    i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [WIDTH-1:0]    o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic [CNT_W-1:0]    pkt_count
);

  state_t              state, state_n;
  logic [SPP_LOG2-1:0] count, count_n;
  logic [SPP_LOG2-1:0] spp_l, spp_l_n;
  logic [SPP_LOG2:0]   count_inc;
  logic                accept;
  logic                tag;
  logic [WIDTH:0]      out_word;

  assign accept    = i_tvalid & i_tready;
  assign count_inc = {1'b0, count} + (SPP_LOG2 + 1)'(1);

`ifndef REFRAME_PASS_TLAST_EN
  logic unused_tlast;
  assign unused_tlast = i_tlast;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= S_START;
      count <= '0;
      spp_l <= SPP_LOG2'(1);
    end else begin
      state <= state_n;
      count <= count_n;
      spp_l <= spp_l_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    spp_l_n = spp_l;
    tag     = 1'b0;
    case (state)
      S_START: begin
        if (accept) begin
          spp_l_n = (spp == '0) ? SPP_LOG2'(1) : spp;
          if (spp_l_n == SPP_LOG2'(1)) begin
            tag = 1'b1;
          end else begin
            count_n = SPP_LOG2'(1);
            state_n = S_MID;
          end
        end
      end
      S_MID: begin
        if (accept) begin
          if (count_inc == {1'b0, spp_l}) begin
            tag     = 1'b1;
            count_n = '0;
            state_n = S_START;
          end else begin
            count_n = count_inc[SPP_LOG2-1:0];
          end
        end
      end
      default: begin
        count_n = '0;
        state_n = S_START;
      end
    endcase
`ifdef REFRAME_PASS_TLAST_EN
    // Upstream tlast closes the packet early; the spp boundary still applies
    if (accept && i_tlast) begin
      tag     = 1'b1;
      count_n = '0;
      state_n = S_START;
    end
`endif
  end

  axis_skid2 #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .s_data ({tag, i_tdata}),
    .s_valid(i_tvalid),
    .s_ready(i_tready),
    .m_data (out_word),
    .m_valid(o_tvalid),
    .m_ready(o_tready)
  );

  assign o_tdata = out_word[WIDTH-1:0];
  assign o_tlast = out_word[WIDTH];

  // Packets are counted as they leave, not when tagged
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pkt_count <= '0;
    end else if (o_tvalid && o_tready && o_tlast) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_reframer.sv
// Randomized bench for axis_reframer with a queue-based framing model.
`default_nettype none
`timescale 1ns/1ps

module tb_axis_reframer;

  localparam int WIDTH    = 16;
  localparam int SPP_LOG2 = 10;
  localparam int CNT_W    = 16;
`ifdef REFRAME_PASS_TLAST_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                clear = 1'b0;
  logic [SPP_LOG2-1:0] spp = '0;
  logic [WIDTH-1:0]    i_tdata = '0;
  logic                i_tlast = 1'b0;
  logic                i_tvalid = 1'b0;
  logic                i_tready;
  logic [WIDTH-1:0]    o_tdata;
  logic                o_tlast;
  logic                o_tvalid;
  logic                o_tready = 1'b1;
  logic [CNT_W-1:0]    pkt_count;

  axis_reframer #(.WIDTH(WIDTH), .SPP_LOG2(SPP_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .spp(spp),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rdy_pct = 100;

  // Model state: expected output words in order, position in packet, latched size
  logic [WIDTH:0] exp_q[$];
  int             pos = 0;
  int             plen = 1;
  int             model_pkt = 0;
  logic [63:0]    tmask = '0;
  bit             was_flush = 1'b0;
  bit             lat_pend = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Compare process: every cycle at the falling edge
  always @(negedge clk) begin
    logic [WIDTH:0] w;
    bit t;
    chk("pkt_count", pkt_count, model_pkt % (1 << CNT_W));
    if (was_flush) begin
      chk("flush_o_tvalid", o_tvalid, 0);
      chk("flush_i_tready", i_tready, 1);
      chk("flush_o_tdata", o_tdata, 0);
      chk("flush_o_tlast", o_tlast, 0);
    end else if (lat_pend) begin
      chk("latency_o_tvalid", o_tvalid, 1);
    end
    lat_pend = 1'b0;
    was_flush = reset || clear;
    if (reset || clear) begin
      exp_q.delete();
      pos = 0;
      model_pkt = 0;
      tmask = '0;
    end else begin
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_emit", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("o_tdata", o_tdata, w[WIDTH-1:0]);
          chk("o_tlast", o_tlast, w[WIDTH]);
          if (w[WIDTH]) begin
            model_pkt++;
            tmask[w[5:0]] = 1'b1;
          end
        end
      end
      if (i_tvalid && i_tready) begin
        if (exp_q.size() == 0) lat_pend = 1'b1;
        if (pos == 0) plen = (spp == 0) ? 1 : int'(spp);
        pos++;
        t = (pos == plen) || (PASS && i_tlast);
        if (t) pos = 0;
        exp_q.push_back({t, i_tdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    i_tvalid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send(input int n, input int base, input int gap, input int tlast_at);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int guard;
      if (gap != 0) begin
        i_tvalid = 1'b0;
        repeat ($urandom_range(0, gap)) tick();
      end
      i_tvalid = 1'b1;
      i_tdata  = WIDTH'(base + k);
      i_tlast  = (k == tlast_at);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 2000) begin
        @(negedge clk);
        acc = i_tready;
        tick();
        guard++;
      end
      if (!acc) chk("input_accept_timeout", 0, 1);
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: spp=4, back-to-back, always ready
    rdy_pct = 100; spp = 4; pulse_clear();
    send(10, 0, 0, -1); drain();
    chk("t1_pkt_count", pkt_count, 2);
    chk("t1_tlast_mask", tmask, 64'h88);

    // 2: spp=3, 50% output ready
    rdy_pct = 50; spp = 3; pulse_clear();
    send(12, 0, 0, -1); drain();
    chk("t2_tlast_mask", tmask, 64'h924);
    chk("t2_pkt_count", pkt_count, 4);

    // 3: spp 4 -> 2 mid-packet
    rdy_pct = 100; spp = 4; pulse_clear();
    send(2, 0, 0, -1); spp = 2; send(8, 2, 0, -1); drain();
    chk("t3_tlast_mask", tmask, 64'h2A8);

    // 4: spp=0 and spp=1 tag every sample
    spp = 0; pulse_clear(); send(5, 0, 0, -1); drain();
    chk("t4_spp0_pkt_count", pkt_count, 5);
    spp = 1; pulse_clear(); send(5, 0, 0, -1); drain();
    chk("t4_spp1_pkt_count", pkt_count, 5);
    chk("t4_spp1_tlast_mask", tmask, 64'h1F);

    // 5: clear mid-packet discards the partial packet
    rdy_pct = 60; spp = 8; pulse_clear();
    send(5, 0, 0, -1); pulse_clear();
    send(8, 10, 0, -1); drain();
    chk("t5_pkt_count", pkt_count, 1);
    chk("t5_tlast_mask", tmask, 64'h1 << 17);

    // 6: upstream tlast on sample 2 with spp=6
    rdy_pct = 100; spp = 6; pulse_clear();
    send(9, 0, 0, 2); drain();
    chk("t6_tlast_mask", tmask, PASS ? 64'h104 : 64'h20);

    // Randomized framing, gaps, backpressure and upstream tlast
    for (int r = 0; r < 40; r++) begin
      rdy_pct = $urandom_range(20, 100);
      spp = SPP_LOG2'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) pulse_clear();
      send($urandom_range(1, 30), $urandom_range(0, 1000), $urandom_range(0, 2),
           $urandom_range(0, 40));
      if ($urandom_range(0, 2) == 0) drain();
    end
    rdy_pct = 100;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
